// File: rtl/dmem_responder_if.sv
// Request/response channel between the load/store unit (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with byte-masked writes and a fixed response
// latency; one outstanding transaction at a time.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] addr_off;
    logic [31:0] word_off;
    logic        in_range;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic        wr_en;

    // Unsigned wrap on the subtraction is harmless: the >= check rejects it.
    assign addr_off = bus.req_addr - BASE_ADDR;
    assign word_off = addr_off >> 2;
    assign in_range = (bus.req_addr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
    assign word_idx = word_off[AW-1:0];

    // Writes commit on the accept edge; no commit while reset is held.
    assign wr_en = rst && bus.req_valid && (state_q == IDLE) && bus.req_we && in_range;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (wr_en && bus.req_wmask[gi]) begin
                    lane_mem[word_idx] <= bus.req_wdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    rsp_err_d   = !in_range;
                    rsp_rdata_d = (!bus.req_we && in_range) ? rd_word : 32'h0;
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Leaving on the edge that brings the counter to zero keeps
                // the response LATENCY edges after the accept for any LATENCY.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=1 driven from a
// vector table, one with LATENCY=4, plus hand sequences for spacing/backpressure/reset.
module tb_dmem_responder;
    logic clk;
    logic rst;

    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_ready;

    logic        m_req_ready;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_err;

    int n_checks;
    int n_fail;

    dmem_responder_if bus1();
    dmem_responder_if bus4();

    assign bus1.req_valid = req_valid && !sel;
    assign bus1.req_we    = req_we;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;
    assign bus1.req_wmask = req_wmask;
    assign bus1.rsp_ready = rsp_ready;

    assign bus4.req_valid = req_valid && sel;
    assign bus4.req_we    = req_we;
    assign bus4.req_addr  = req_addr;
    assign bus4.req_wdata = req_wdata;
    assign bus4.req_wmask = req_wmask;
    assign bus4.rsp_ready = rsp_ready;

    assign m_req_ready = sel ? bus4.req_ready : bus1.req_ready;
    assign m_rsp_valid = sel ? bus4.rsp_valid : bus1.rsp_valid;
    assign m_rsp_rdata = sel ? bus4.rsp_rdata : bus1.rsp_rdata;
    assign m_rsp_err   = sel ? bus4.rsp_err   : bus1.rsp_err;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(4)) u_lat4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input logic s, input vec_t v, input int exp_lat, input string nm);
        int lat;
        logic rdy_low;
        sel = s;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({nm, " req_ready_idle"}, 32'(m_req_ready), 32'd1);
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wmask = v.mask;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        rdy_low = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (m_rsp_valid) begin
                lat = k;
                break;
            end
            if (m_req_ready) rdy_low = 1'b0;
            @(posedge clk);
            #1;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " ready_low_wait"}, 32'(rdy_low), 32'd1);
        chk({nm, " ready_low_resp"}, 32'(m_req_ready), 32'd0);
        chk({nm, " rdata"}, m_rsp_rdata, v.exp_rdata);
        chk({nm, " err"}, 32'(m_rsp_err), 32'(v.exp_err));
        $display("txn %s sel=%0d we=%0d addr=%h wdata=%h mask=%h -> rdata=%h err=%0d lat=%0d",
                 nm, s, v.we, v.addr, v.wdata, v.mask, m_rsp_rdata, m_rsp_err, lat);
        @(posedge clk);
        #1;
        chk({nm, " valid_after_hs"}, 32'(m_rsp_valid), 32'd0);
        chk({nm, " ready_after_hs"}, 32'(m_req_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h0000_AA00, 4'h2, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h8000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_0FFC, 32'h1122_3344, 4'h0, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0FFF, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0};
        vecs[12] = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h9, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h8000_0012, 32'h0,         4'h0, 32'h11AD_AA44, 1'b0};
        vecs[14] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_C0DE, 4'hF, 32'h0000_0000, 1'b1};
        vecs[15] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};

        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wmask = 4'h0;
        rsp_ready = 1'b0;
        rst       = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(bus1.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        chk("reset rsp_rdata", bus1.rsp_rdata, 32'h0);
        chk("reset rsp_err", 32'(bus1.rsp_err), 32'd0);
        chk("reset4 req_ready", 32'(bus4.req_ready), 32'd1);
        chk("reset4 rsp_valid", 32'(bus4.rsp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset req_ready", 32'(bus1.req_ready), 32'd1);
        chk("post_reset rsp_valid", 32'(bus1.rsp_valid), 32'd0);

        for (int i = 0; i < 16; i++) begin
            txn(1'b0, vecs[i], 1, $sformatf("vec%0d", i));
        end

        // Back-to-back reads with req_valid held: accepts every 2 cycles.
        sel = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_we    = 1'b0;
        req_addr  = 32'h8000_0010;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("spacing valid%0d", i), 32'(m_rsp_valid), 32'((i % 2) == 0));
            chk($sformatf("spacing ready%0d", i), 32'(m_req_ready), 32'((i % 2) == 1));
            if ((i % 2) == 0) chk($sformatf("spacing rdata%0d", i), m_rsp_rdata, 32'h11AD_AA44);
            $display("spacing cycle %0d valid=%0d ready=%0d", i, m_rsp_valid, m_req_ready);
        end
        req_valid = 1'b0;

        // LATENCY=4 instance.
        v = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        txn(1'b1, v, 4, "lat4_wr");
        v = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        txn(1'b1, v, 4, "lat4_rd");
        v = '{1'b0, 32'h8000_2000, 32'h0, 4'h0, 32'h0, 1'b1};
        txn(1'b1, v, 4, "lat4_oor");

        // Backpressure in RESP, then reset while the response is pending.
        sel = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_we    = 1'b0;
        req_addr  = 32'h8000_0010;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall valid%0d", i), 32'(m_rsp_valid), 32'd1);
            chk($sformatf("stall rdata%0d", i), m_rsp_rdata, 32'h11AD_AA44);
            $display("stall cycle %0d valid=%0d rdata=%h", i, m_rsp_valid, m_rsp_rdata);
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("abort rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("abort rsp_rdata", m_rsp_rdata, 32'h0);
        chk("abort req_ready", 32'(m_req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release req_ready", 32'(m_req_ready), 32'd1);
        chk("release rsp_valid", 32'(m_rsp_valid), 32'd0);

        v = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h11AD_AA44, 1'b0};
        txn(1'b0, v, 1, "persist1");
        v = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0};
        txn(1'b0, v, 1, "persist1_w0");
        v = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        txn(1'b1, v, 4, "persist4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
